counter_seq_ctrl: RTL and testbench

- Run/stop sequencer for the 8-bit output counter datapath; behaves as a stopwatch controller.
- Turns raw button pins (start, stop, lap, clear) into synchronised single-cycle events.
- Paces the counter with a programmable tick prescaler and drives its increment-enable and clear.
- Selects live count or a frozen lap value for display on uo_out.

---
 rtl/counter_seq_pkg.sv | 46 ++++
 rtl/btn_event.sv | 49 ++++
 rtl/counter_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// ---------------------------------------------------------------------------
// counter_seq_pkg
// Shared definitions for the stopwatch run/stop sequencer:
//   - state_t    : controller state, encoded exactly as presented on state_o
//   - event_t    : winning button event of a cycle after priority resolution
//   - BTN_*      : bit positions of the four buttons in the event vector
//   - pick_event : priority resolver, clear > stop > start > lap
//   - DEFAULT_DIV / DEFAULT_MAX_COUNT : default tick divider and wrap value
// ---------------------------------------------------------------------------
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_CLEAR = 3'd1,
        EV_STOP  = 3'd2,
        EV_START = 3'd3,
        EV_LAP   = 3'd4
    } event_t;

    // Bit positions of each button inside the 4-bit event vector.
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_CLEAR = 3;

    localparam int DEFAULT_DIV       = 4;
    localparam int DEFAULT_MAX_COUNT = 255;

    // Only the highest-priority event of a cycle survives; the rest are
    // dropped, even if the winner turns out to be ignored in the current state.
    function automatic event_t pick_event(input logic [3:0] ev);
        if (ev[BTN_CLEAR])      return EV_CLEAR;
        else if (ev[BTN_STOP])  return EV_STOP;
        else if (ev[BTN_START]) return EV_START;
        else if (ev[BTN_LAP])   return EV_LAP;
        else                    return EV_NONE;
    endfunction

endpackage

// File: rtl/btn_event.sv
// ---------------------------------------------------------------------------
// btn_event
// Converts one asynchronous button pin into a single-cycle event pulse:
// two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous reset, active-high
//   pin   in  1  raw asynchronous button pin
//   pulse out 1  one-cycle event, high in the cycle before the 3rd clk edge
//                after the pin rises
// A button still held when reset is released produces no event: the detector
// is only armed once a genuine low sample has been seen after reset, so the
// button must be released and pressed again.
// ---------------------------------------------------------------------------
module btn_event (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pulse
);

    logic sync1;   // first synchroniser stage (may be metastable)
    logic sync2;   // second synchroniser stage, safe to use
    logic prev;    // sync2 delayed, for edge detection
    logic primed;  // sync1 holds a real post-reset sample
    logic armed;   // a real low level has been observed since reset

    // NOTE: all state here is updated with non-blocking assignments so every
    // stage samples the previous cycle's value of the stage before it; a
    // blocking chain would collapse the synchroniser into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= pin;
            sync2  <= sync1;
            prev   <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1);
        end
    end

    assign pulse = sync2 & ~prev & armed;

endmodule

// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
// Stopwatch-style run/stop sequencer for an external 8-bit counter datapath.
// Conditions four buttons into events, paces the counter with a programmable
// tick prescaler, handles clear and wrap, and muxes live count or a frozen
// lap value onto the display.
// Parameters:
//   DIV        clock cycles per count tick (2..65536)
//   MAX_COUNT  last count value before wrap (<= 255)
// Ports:
//   clk        in  1  clock
//   rst        in  1  synchronous reset, active-high (shared with datapath)
//   start_i    in  1  start/resume button, asynchronous
//   stop_i     in  1  pause button, asynchronous
//   lap_i      in  1  lap freeze/release button, asynchronous
//   clear_i    in  1  clear button, asynchronous
//   cnt_val_i  in  8  current counter value from the datapath
//   cnt_en_o   out 1  one-cycle increment enable to the counter
//   cnt_clr_o  out 1  one-cycle clear to the counter (wins over increment)
//   disp_o     out 8  displayed value: lap_reg in LAP, else live count
//   state_o    out 2  IDLE=00, RUN=01, PAUSE=10, LAP=11
//   ovf_o      out 1  sticky wrap flag, cleared by clear event or rst
// ---------------------------------------------------------------------------
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int DIV       = DEFAULT_DIV,
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       lap_i,
    input  logic       clear_i,
    input  logic [7:0] cnt_val_i,
    output logic       cnt_en_o,
    output logic       cnt_clr_o,
    output logic [7:0] disp_o,
    output logic [1:0] state_o,
    output logic       ovf_o
);

    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [7:0]    CNT_LAST   = 8'(MAX_COUNT);

    // ---------------- button conditioning ----------------
    logic [3:0] ev;

    btn_event u_start (.clk(clk), .rst(rst), .pin(start_i), .pulse(ev[BTN_START]));
    btn_event u_stop  (.clk(clk), .rst(rst), .pin(stop_i),  .pulse(ev[BTN_STOP]));
    btn_event u_lap   (.clk(clk), .rst(rst), .pin(lap_i),   .pulse(ev[BTN_LAP]));
    btn_event u_clear (.clk(clk), .rst(rst), .pin(clear_i), .pulse(ev[BTN_CLEAR]));

    event_t win;
    assign win = pick_event(ev);

    // ---------------- FSM ----------------
    state_t state;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets its default before the case so every path assigns
    // it; without that, an unhandled event would infer a latch.
    always_comb begin
        next_state = state;
        if (win == EV_CLEAR) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win == EV_START) next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (win == EV_STOP)     next_state = ST_PAUSE;
                    else if (win == EV_LAP) next_state = ST_LAP;
                end
                ST_LAP: begin
                    if (win == EV_STOP)     next_state = ST_PAUSE;
                    else if (win == EV_LAP) next_state = ST_RUN;
                end
                ST_PAUSE: begin
                    if (win == EV_START) next_state = ST_RUN;
                end
            endcase
        end
    end

    // ---------------- prescaler, lap register, tick/clear/ovf ----------------
    logic [PW-1:0] presc;
    logic [7:0]    lap_reg;
    logic          en_q;
    logic          clr_q;
    logic          ovf_q;
    logic          running_now;
    logic          running_next;
    logic          keep_running;
    logic          wrap;

    assign running_now  = (state == ST_RUN) || (state == ST_LAP);
    assign running_next = (next_state == ST_RUN) || (next_state == ST_LAP);
    // The prescaler only advances on edges that stay inside RUN/LAP, so a stop
    // freezes it at its current phase and a later resume continues from there;
    // a tick already registered in en_q still issues, but none follow.
    assign keep_running = running_now && running_next;

    // A tick landing on the last count value clears instead of incrementing.
    assign wrap = en_q && (cnt_val_i == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            lap_reg <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            en_q  <= 1'b0;
            clr_q <= (win == EV_CLEAR);
            if (win == EV_CLEAR) begin
                presc   <= '0;
                lap_reg <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (wrap) ovf_q <= 1'b1;

                if (state == ST_IDLE && win == EV_START) begin
                    presc <= '0;
                end else if (keep_running) begin
                    if (presc == PRESC_LAST) begin
                        presc <= '0;
                        en_q  <= 1'b1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end

                if (state == ST_RUN && win == EV_LAP) lap_reg <= cnt_val_i;
            end
        end
    end

    // ---------------- outputs ----------------
    assign cnt_en_o  = en_q;
    assign cnt_clr_o = clr_q | wrap;
    assign ovf_o     = ovf_q;
    assign state_o   = state;
    assign disp_o    = (state == ST_LAP) ? lap_reg : cnt_val_i;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
// Self-checking bench for counter_seq_ctrl (DIV=4, MAX_COUNT=255) with an
// 8-bit datapath counter attached. A reference model steps once per clock
// edge and queues the outputs expected for the following cycle; a monitor on
// the falling edge pops each entry and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    localparam int DIV       = 4;
    localparam int MAX_COUNT = 255;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_LAP   = 2;
    localparam int B_CLEAR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [7:0] cnt_val;
    logic       cnt_en;
    logic       cnt_clr;
    logic [7:0] disp;
    logic [1:0] state;
    logic       ovf;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.DIV(DIV), .MAX_COUNT(MAX_COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (btn[B_START]),
        .stop_i    (btn[B_STOP]),
        .lap_i     (btn[B_LAP]),
        .clear_i   (btn[B_CLEAR]),
        .cnt_val_i (cnt_val),
        .cnt_en_o  (cnt_en),
        .cnt_clr_o (cnt_clr),
        .disp_o    (disp),
        .state_o   (state),
        .ovf_o     (ovf)
    );

    // Attached datapath counter, driven by the DUT's enable/clear.
    always @(posedge clk) begin
        if (rst)          cnt_val <= 8'd0;
        else if (cnt_clr) cnt_val <= 8'd0;
        else if (cnt_en)  cnt_val <= cnt_val + 8'd1;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0] state;
        logic       en;
        logic       clr;
        logic [7:0] disp;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    // Event rule: a button's event is applied at edge k when its pin was
    // sampled high at edge k-2 and low at edge k-3, both samples taken after
    // reset was released.
    int       m_state;
    int       m_run_cycles;   // cycles spent advancing since start-from-idle/clear
    int       m_cnt;
    int       m_lap;
    bit       m_en;
    bit       m_clrq;
    bit       m_ovf;
    int       n_gen;
    bit [2:0] hist [4];       // [0]=last edge, [1]=two edges ago, [2]=three ago

    always @(posedge clk) begin
        exp_t e;
        bit [3:0] evs;
        int  winner;
        int  nxt_state;
        bit  wrap_now;
        bit  clr_now;
        bit  nxt_en;
        bit  run_now;
        bit  run_next;
        if (rst) begin
            m_state = S_IDLE; m_run_cycles = 0; m_cnt = 0; m_lap = 0;
            m_en = 0; m_clrq = 0; m_ovf = 0; n_gen = 0;
            for (int b = 0; b < 4; b++) hist[b] = 3'b000;
        end else begin
            for (int b = 0; b < 4; b++)
                evs[b] = (n_gen >= 3) && hist[b][1] && !hist[b][2];
            if (evs[B_CLEAR])      winner = B_CLEAR;
            else if (evs[B_STOP])  winner = B_STOP;
            else if (evs[B_START]) winner = B_START;
            else if (evs[B_LAP])   winner = B_LAP;
            else                   winner = -1;

            wrap_now = m_en && (m_cnt == MAX_COUNT);
            clr_now  = m_clrq || wrap_now;

            nxt_state = m_state;
            if (winner == B_CLEAR) nxt_state = S_IDLE;
            else if (m_state == S_IDLE  && winner == B_START) nxt_state = S_RUN;
            else if (m_state == S_RUN   && winner == B_STOP)  nxt_state = S_PAUSE;
            else if (m_state == S_RUN   && winner == B_LAP)   nxt_state = S_LAP;
            else if (m_state == S_LAP   && winner == B_STOP)  nxt_state = S_PAUSE;
            else if (m_state == S_LAP   && winner == B_LAP)   nxt_state = S_RUN;
            else if (m_state == S_PAUSE && winner == B_START) nxt_state = S_RUN;

            run_now  = (m_state == S_RUN) || (m_state == S_LAP);
            run_next = (nxt_state == S_RUN) || (nxt_state == S_LAP);
            nxt_en   = 0;

            if (winner == B_CLEAR) begin
                m_run_cycles = 0; m_lap = 0; m_ovf = 0;
            end else begin
                if (wrap_now) m_ovf = 1;
                if (m_state == S_IDLE && winner == B_START) begin
                    m_run_cycles = 0;
                end else if (run_now && run_next) begin
                    m_run_cycles++;
                    nxt_en = (m_run_cycles % DIV) == 0;
                end
                if (m_state == S_RUN && winner == B_LAP) m_lap = m_cnt;
            end
            m_clrq = (winner == B_CLEAR);

            if (clr_now)   m_cnt = 0;
            else if (m_en) m_cnt = (m_cnt + 1) % 256;
            m_en    = nxt_en;
            m_state = nxt_state;

            for (int b = 0; b < 4; b++) hist[b] = {hist[b][1:0], btn[b]};
            if (n_gen < 3) n_gen++;
        end
        e.state = 2'(m_state);
        e.en    = m_en;
        e.clr   = m_clrq || (m_en && m_cnt == MAX_COUNT);
        e.disp  = (m_state == S_LAP) ? 8'(m_lap) : 8'(m_cnt);
        e.ovf   = m_ovf;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state_o",   32'(state),   32'(e.state));
            check("cnt_en_o",  32'(cnt_en),  32'(e.en));
            check("cnt_clr_o", 32'(cnt_clr), 32'(e.clr));
            check("disp_o",    32'(disp),    32'(e.disp));
            check("ovf_o",     32'(ovf),     32'(e.ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        btn = btn | mask;
        step(hold);
        btn = btn & ~mask;
        step(1);
    endtask

    task automatic wait_model(input int target_cnt, input int budget, input string name);
        int guard;
        guard = 0;
        while (m_cnt != target_cnt && guard < budget) begin
            step(1);
            guard++;
        end
        check(name, 32'(guard < budget), 32'd1);
    endtask

    initial begin
        logic [3:0] m;
        int guard;

        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(5);

        // Start from IDLE, let a few ticks accumulate.
        press(4'b0001 << B_START, 5);
        step(20);

        // Lap freeze at count 5, then release.
        wait_model(5, 200, "reach_cnt5");
        press(4'b0001 << B_LAP, 1);
        step(30);
        press(4'b0001 << B_LAP, 1);
        step(15);

        // Stop with the prescaler at phase 2, hold it, then resume.
        guard = 0;
        while (!(m_state == S_RUN && (m_run_cycles % DIV) == 0) && guard < 50) begin
            step(1);
            guard++;
        end
        check("align_stop", 32'(guard < 50), 32'd1);
        press(4'b0001 << B_STOP, 50);
        step(5);
        press(4'b0001 << B_START, 2);
        step(20);

        // Run up to the wrap, then stop/start and clear the sticky flag.
        wait_model(254, 1500, "reach_cnt254");
        step(20);
        press(4'b0001 << B_STOP, 2);
        step(10);
        press(4'b0001 << B_START, 2);
        step(10);
        press(4'b0001 << B_CLEAR, 2);
        step(10);

        // Start and clear together while paused.
        press(4'b0001 << B_START, 2);
        step(12);
        press(4'b0001 << B_STOP, 2);
        step(10);
        press((4'b0001 << B_START) | (4'b0001 << B_CLEAR), 3);
        step(20);

        // Reset in LAP with start held; no event until released and re-pressed.
        press(4'b0001 << B_START, 2);
        step(10);
        press(4'b0001 << B_LAP, 2);
        step(6);
        btn[B_START] = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);
        btn[B_START] = 1'b0;
        step(5);
        press(4'b0001 << B_START, 2);
        step(20);

        // Randomised button traffic with occasional resets.
        for (int i = 0; i < 150; i++) begin
            m = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) m[B_CLEAR] = 1'b0;
            if (m == 4'b0000) m = 4'b0001;
            press(m, $urandom_range(1, 6));
            step($urandom_range(0, 60));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
